// File: rtl/comparator_pkg.sv
// Shared types and sizing helpers for the serial word comparator.
// Pure declarations; no latency and no flow control of its own.
// Included by the top and by any block that needs the flag or state types.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;

    localparam int CMP_DEFAULT_WIDTH = 8;

    function automatic int cmp_nslice(input int width);
        return width / 2;
    endfunction

    // Index register never collapses to zero bits, even for a single slice.
    function automatic int cmp_idx_w(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

endpackage

// File: rtl/binary_comparator_2bit.sv
// Unsigned magnitude compare of two 2-bit slices.
// Purely combinational, zero latency.
// No flow control; the caller sequences the inputs.
module binary_comparator_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_word_comparator.sv
// Word magnitude compare, MSB-first in 2-bit slices, stopping at the first unequal slice.
// Latency: result valid 1..WIDTH/2 edges after accept.
// Backpressure: DONE holds flags and blocks new operands until res_ready.
module serial_word_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = CMP_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
);

    localparam int NSLICE = cmp_nslice(WIDTH);
    localparam int IDX_W  = cmp_idx_w(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    cmp_state_t       state;
    cmp_flags_t       flags_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx;

    logic [1:0] slice_a;
    logic [1:0] slice_b;
    logic       slice_gt;
    logic       slice_eq;
    logic       slice_lt;

    // Constant-index mux keeps the select free of index-width games for any WIDTH.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                slice_a = a_q[2*i +: 2];
                slice_b = b_q[2*i +: 2];
            end
        end
    end

    binary_comparator_2bit u_slice_cmp (
        .a  (slice_a),
        .b  (slice_b),
        .gt (slice_gt),
        .eq (slice_eq),
        .lt (slice_lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            flags_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        idx   <= IDX_LAST;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!slice_eq) begin
                        flags_q.gt <= slice_gt;
                        flags_q.eq <= 1'b0;
                        flags_q.lt <= slice_lt;
                        state      <= DONE;
                    end else if (idx == '0) begin
                        flags_q.gt <= 1'b0;
                        flags_q.eq <= 1'b1;
                        flags_q.lt <= 1'b0;
                        state      <= DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign a_gt_b      = flags_q.gt;
    assign a_eq_b      = flags_q.eq;
    assign a_lt_b      = flags_q.lt;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Bench for serial_word_comparator: an 8-bit instance for directed and random
// scenarios and a 2-bit instance for the exhaustive back-to-back sweep.
module tb_serial_word_comparator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sv8 = 1'b0, rr8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       sr8, rv8, gt8, eq8, lt8;

    logic       sv2 = 1'b0, rr2 = 1'b1;
    logic [1:0] a2 = '0, b2 = '0;
    logic       sr2, rv2, gt2, eq2, lt2;

    int vectors = 0;
    int miscompares = 0;

    serial_word_comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .a_in(a8), .b_in(b8), .res_valid(rv8), .res_ready(rr8),
        .a_gt_b(gt8), .a_eq_b(eq8), .a_lt_b(lt8)
    );

    serial_word_comparator #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(sr2),
        .a_in(a2), .b_in(b2), .res_valid(rv2), .res_ready(rr2),
        .a_gt_b(gt2), .a_eq_b(eq2), .a_lt_b(lt2)
    );

    // Reference: flags from plain unsigned compare, {gt, eq, lt}.
    function automatic logic [2:0] ref_flags(input int unsigned a, input int unsigned b);
        return {a > b, a == b, a < b};
    endfunction

    // Reference: slices examined = slices from the top down to the highest differing bit.
    function automatic int ref_k(input int unsigned a, input int unsigned b, input int nslice);
        int unsigned diff = a ^ b;
        int hi = -1;
        for (int i = 0; i < 32; i++)
            if (diff[i]) hi = i;
        if (hi < 0) return nslice;
        return nslice - hi / 2;
    endfunction

    // Drives one 8-bit operation from IDLE and reports what came back.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold,
                       output int lat, output logic [2:0] fl);
        a8 = a; b8 = b; sv8 = 1'b1; rr8 = 1'b0;
        @(posedge clk); #1;
        sv8 = 1'b0; a8 = ~a; b8 = ~b;
        lat = 0;
        while (!rv8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        fl = {gt8, eq8, lt8};
        repeat (hold) @(posedge clk);
        #1 rr8 = 1'b1;
        @(posedge clk); #1;
        rr8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({sr8, rv8, gt8, eq8, lt8} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset8: got {rdy,vld,gt,eq,lt}=%b want 10000", {sr8, rv8, gt8, eq8, lt8});
        end
        vectors++;
        if ({sr2, rv2, gt2, eq2, lt2} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset2: got {rdy,vld,gt,eq,lt}=%b want 10000", {sr2, rv2, gt2, eq2, lt2});
        end
    endtask

    task automatic test_directed();
        logic [7:0] av [3] = '{8'hC5, 8'hA5, 8'h1E};
        logic [7:0] bv [3] = '{8'h35, 8'hA5, 8'h1F};
        int         kv [3] = '{1, 4, 4};
        logic [2:0] fv [3] = '{3'b100, 3'b010, 3'b001};
        int lat;
        logic [2:0] fl;
        for (int i = 0; i < 3; i++) begin
            op8(av[i], bv[i], 0, lat, fl);
            vectors++;
            if (fl !== fv[i] || lat != kv[i]) begin
                miscompares++;
                $display("FAIL directed %h/%h: got flags=%b k=%0d want flags=%b k=%0d",
                         av[i], bv[i], fl, lat, fv[i], kv[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        a8 = 8'h40; b8 = 8'h80; sv8 = 1'b1; rr8 = 1'b0;
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'h00;
        while (!rv8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat != 1) begin
            miscompares++;
            $display("FAIL bp_latency: got k=%0d want 1", lat);
        end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({sr8, rv8, gt8, eq8, lt8} !== 5'b01001) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: got {rdy,vld,gt,eq,lt}=%b want 01001",
                         c, {sr8, rv8, gt8, eq8, lt8});
            end
            @(posedge clk); #1;
        end
        rr8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0; rr8 = 1'b0;
        vectors++;
        if ({sr8, rv8, lt8} !== 3'b101) begin
            miscompares++;
            $display("FAIL bp_release: got {rdy,vld,lt}=%b want 101", {sr8, rv8, lt8});
        end
        @(posedge clk); #1;
        vectors++;
        if ({sr8, rv8} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_no_accept: got {rdy,vld}=%b want 10", {sr8, rv8});
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        logic [2:0] fl;
        logic seen_vld = 1'b0;
        a8 = 8'h00; b8 = 8'h01; sv8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vectors++;
        if ({sr8, rv8, gt8, eq8, lt8} !== 5'b10000) begin
            miscompares++;
            $display("FAIL mid_reset: got {rdy,vld,gt,eq,lt}=%b want 10000", {sr8, rv8, gt8, eq8, lt8});
        end
        repeat (6) begin
            @(posedge clk); #1;
            if (rv8) seen_vld = 1'b1;
        end
        vectors++;
        if (seen_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_pulse: got res_valid pulse=%b want 0", seen_vld);
        end
        op8(8'h00, 8'h01, 1, lat, fl);
        vectors++;
        if (fl !== 3'b001 || lat != 4) begin
            miscompares++;
            $display("FAIL mid_reset_next: got flags=%b k=%0d want 001 k=4", fl, lat);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [2:0] fl;
        logic [7:0] a, b;
        for (int n = 0; n < 150; n++) begin
            a = 8'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 8'($urandom_range(1, 3));
                2: b = a ^ 8'($urandom_range(1, 15));
                default: b = 8'($urandom);
            endcase
            op8(a, b, $urandom_range(0, 3), lat, fl);
            vectors++;
            if (fl !== ref_flags(a, b) || lat != ref_k(a, b, 4)) begin
                miscompares++;
                $display("FAIL random %h/%h: got flags=%b k=%0d want flags=%b k=%0d",
                         a, b, fl, lat, ref_flags(a, b), ref_k(a, b, 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, wait_c;
        rr2 = 1'b1; sv2 = 1'b1;
        for (int p = 0; p < 16; p++) begin
            logic [3:0] pair;
            pair = 4'(p);
            wait_c = 0;
            while (!sr2 && wait_c < 10) begin
                @(posedge clk); #1;
                wait_c++;
            end
            a2 = pair[3:2]; b2 = pair[1:0];
            @(posedge clk); #1;
            a2 = ~pair[3:2]; b2 = ~pair[1:0];
            lat = 0;
            while (!rv2 && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            vectors++;
            if ({gt2, eq2, lt2} !== ref_flags(pair[3:2], pair[1:0]) || lat != 1) begin
                miscompares++;
                $display("FAIL sweep %0d/%0d: got flags=%b k=%0d want flags=%b k=1",
                         pair[3:2], pair[1:0], {gt2, eq2, lt2}, lat, ref_flags(pair[3:2], pair[1:0]));
            end
            @(posedge clk); #1;
        end
        sv2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
